// File: rtl/apb_mem_master_pkg.sv
// Shared definitions for the APB data-memory master: FSM state encoding
// and the default widths used by the processor top.
package apb_mem_master_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 6;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    function automatic logic bus_active(input apb_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/apb_mem_master_if.sv
// APB bus bundle between the data-memory master and the APB memory slave.
interface apb_mem_master_if
    import apb_mem_master_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_mem_master_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY; expired flags the abort point.
module apb_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_r;

    assign expired = (count_r == CNT_W'(TIMEOUT));

    // Saturating wait counter: stops at TIMEOUT so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/apb_mem_master.sv
// APB master for the data-memory port: SETUP/ACCESS sequencing with wait
// states, timeout abort, back-to-back issue and a pipeline stall output.
module apb_mem_master
    import apb_mem_master_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    apb_mem_master_if.master  apb
);

    apb_state_e        state_r;
    apb_state_e        next_state_s;
    logic              req_ready_s;
    logic              accept_s;
    logic              complete_s;
    logic              timeout_s;
    logic              expired_s;
    logic              timer_clear_s;
    logic              timer_enable_s;

    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .enable  (timer_enable_s),
        .expired (expired_s)
    );

    // Next-state, handshake and timer control decode.
    always_comb begin
        next_state_s   = state_r;
        timeout_s      = (state_r == ST_ACCESS) & ~apb.pready & expired_s;
        complete_s     = (state_r == ST_ACCESS) & apb.pready;
        req_ready_s    = (state_r == ST_IDLE) | ((state_r == ST_ACCESS) & apb.pready & ~timeout_s);
        accept_s       = req_valid & req_ready_s;
        case (state_r)
            ST_IDLE: begin
                next_state_s = accept_s ? ST_SETUP : ST_IDLE;
            end
            ST_SETUP: begin
                next_state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A completing ACCESS may hand straight over to the next SETUP.
                if (complete_s) begin
                    next_state_s = accept_s ? ST_SETUP : ST_IDLE;
                end else if (timeout_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        timer_clear_s  = (next_state_s == ST_SETUP);
        timer_enable_s = (state_r == ST_ACCESS) & ~apb.pready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bus strobes follow the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            psel_r    <= bus_active(next_state_s);
            penable_r <= (next_state_s == ST_ACCESS);
        end
    end

    // Request latch: holds address, data and direction for the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite_r <= 1'b0;
            paddr_r  <= {ADDR_W{1'b0}};
            pwdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            pwrite_r <= req_write;
            paddr_r  <= req_addr;
            pwdata_r <= req_wdata;
        end else begin
            pwrite_r <= pwrite_r;
            paddr_r  <= paddr_r;
            pwdata_r <= pwdata_r;
        end
    end

    // Response registers: one-cycle pulse after completion or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (complete_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : apb.prdata;
            rsp_err_r   <= apb.pslverr;
        end else if (timeout_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b1;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end
    end

    assign req_ready   = req_ready_s;
    assign stall       = req_valid & ~req_ready_s;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign rsp_err     = rsp_err_r;
    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.paddr   = paddr_r;
    assign apb.pwdata  = pwdata_r;

endmodule

// File: tb/tb_apb_mem_master.sv
// Self-checking bench for apb_mem_master: directed cases plus randomized
// transfers against a transaction-level memory/latency model.
module tb_apb_mem_master;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    wire           req_ready;
    wire           stall;
    wire           rsp_valid;
    wire [DW-1:0]  rsp_rdata;
    wire           rsp_err;

    apb_mem_master_if #(.DATA_W(DW), .ADDR_W(AW)) apb ();

    apb_mem_master #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] slave_mem [64];
    logic [DW-1:0] model_mem [64];
    int            wait_cfg = 0;
    bit            err_cfg  = 1'b0;
    int            acc_cnt  = 0;
    bit            prev_done  = 1'b0;
    bit            prev_write = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    logic [DW-1:0] prev_wdata = '0;

    // APB slave: PREADY after wait_cfg wait states; garbage data when not ready.
    always @(posedge clk) begin
        #1;
        if (prev_done && prev_write) slave_mem[prev_addr] = prev_wdata;
        if (apb.psel && apb.penable) acc_cnt = acc_cnt + 1;
        else acc_cnt = 0;
        apb.pready  = apb.psel && apb.penable && (acc_cnt == wait_cfg + 1);
        apb.prdata  = apb.pready ? slave_mem[apb.paddr] : DW'($urandom);
        apb.pslverr = apb.pready ? err_cfg : 1'($urandom);
        prev_done   = apb.pready;
        prev_write  = apb.pwrite;
        prev_addr   = apb.paddr;
        prev_wdata  = apb.pwdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One isolated transfer from IDLE; the DUT must be idle on entry.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int waits, input bit err, input bit hold, input string tag);
        bit            to;
        int            eff;
        int            last_acc;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        to       = (waits > TO);
        eff      = to ? TO : waits;
        last_acc = 2 + eff;
        exp_rd   = (wr || to) ? '0 : model_mem[addr];
        exp_err  = to ? 1'b1 : err;
        if (wr && !to) model_mem[addr] = wd;
        wait_cfg = waits;
        err_cfg  = err;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        check({tag, "_ready_idle"}, req_ready, 1);
        for (int k = 1; k <= last_acc + 1; k++) begin
            step();
            if (hold && k < last_acc) begin
                req_valid = 1'b1;
                req_write = ~wr;
                req_addr  = ~addr;
                req_wdata = ~wd;
            end else begin
                req_valid = 1'b0;
            end
            check({tag, "_psel"}, apb.psel, (k <= last_acc));
            check({tag, "_penable"}, apb.penable, (k >= 2 && k <= last_acc));
            check({tag, "_rsp_valid"}, rsp_valid, (k == last_acc + 1));
            if (k <= last_acc) begin
                check({tag, "_paddr"}, apb.paddr, addr);
                check({tag, "_pwdata"}, apb.pwdata, wd);
                check({tag, "_pwrite"}, apb.pwrite, wr);
            end
            if (hold && k < last_acc) begin
                check({tag, "_stall"}, stall, 1);
                check({tag, "_ready_busy"}, req_ready, 0);
            end
            if (k == last_acc + 1) begin
                check({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
                check({tag, "_rsp_err"}, rsp_err, exp_err);
            end
        end
        check({tag, "_ready_after"}, req_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        int            r;
        int            w;

        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = DW'($urandom);
            model_mem[i] = slave_mem[i];
        end
        slave_mem[5] = 16'hBEEF;
        model_mem[5] = 16'hBEEF;

        rst = 1'b1;
        repeat (3) step();
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        check("rst_pwrite", apb.pwrite, 0);
        check("rst_paddr", apb.paddr, 0);
        check("rst_pwdata", apb.pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        step();
        check("idle_ready", req_ready, 1);

        xfer(1'b0, 6'h05, 16'h0000, 0, 1'b0, 1'b0, "t1_load");
        check("t1_beef", model_mem[5], 16'hBEEF);
        xfer(1'b1, 6'h3F, 16'h1234, 3, 1'b0, 1'b1, "t2_store");
        xfer(1'b0, 6'h3F, 16'h0000, 0, 1'b0, 1'b0, "t2_readback");
        xfer(1'b0, 6'h07, 16'h0000, 1000, 1'b0, 1'b0, "t3_timeout");
        xfer(1'b0, 6'h08, 16'h0000, 1, 1'b0, 1'b0, "t3_next");

        // Back-to-back loads: second SETUP directly follows first ACCESS.
        wait_cfg  = 0;
        err_cfg   = 1'b0;
        exp_a     = model_mem[1];
        exp_b     = model_mem[2];
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 6'd1;
        step();
        req_valid = 1'b0;
        check("t4_setup_a_psel", apb.psel, 1);
        check("t4_setup_a_pen", apb.penable, 0);
        step();
        check("t4_access_a_pen", apb.penable, 1);
        req_valid = 1'b1;
        req_addr  = 6'd2;
        check("t4_ready_b2b", req_ready, 1);
        step();
        req_valid = 1'b0;
        check("t4_rsp_a_valid", rsp_valid, 1);
        check("t4_rsp_a_rdata", rsp_rdata, exp_a);
        check("t4_setup_b_psel", apb.psel, 1);
        check("t4_setup_b_pen", apb.penable, 0);
        check("t4_setup_b_paddr", apb.paddr, 2);
        step();
        check("t4_access_b_valid", rsp_valid, 0);
        check("t4_access_b_pen", apb.penable, 1);
        step();
        check("t4_rsp_b_valid", rsp_valid, 1);
        check("t4_rsp_b_rdata", rsp_rdata, exp_b);
        check("t4_rsp_b_err", rsp_err, 0);
        check("t4_idle_psel", apb.psel, 0);

        xfer(1'b1, 6'h09, 16'hA5A5, 0, 1'b1, 1'b0, "t5_err_store");
        xfer(1'b0, 6'h09, 16'h0000, 0, 1'b0, 1'b0, "t5_next_load");

        xfer(1'b0, 6'h0A, 16'h0000, TO, 1'b0, 1'b0, "bnd_waits_eq_to");
        xfer(1'b0, 6'h0B, 16'h0000, TO + 1, 1'b0, 1'b0, "bnd_waits_to_p1");

        // Reset in the middle of a pending load kills it silently.
        wait_cfg  = 1000;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 6'h03;
        step();
        req_valid = 1'b0;
        step();
        check("t6_in_access", apb.penable, 1);
        step();
        rst = 1'b1;
        step();
        check("t6_psel", apb.psel, 0);
        check("t6_penable", apb.penable, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        wait_cfg = 0;
        step();
        check("t6_ready", req_ready, 1);
        check("t6_rsp_valid2", rsp_valid, 0);
        step();
        check("t6_rsp_valid3", rsp_valid, 0);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            w = (r == 0) ? (TO + 1 + $urandom_range(0, 3)) : $urandom_range(0, 4);
            xfer(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), w,
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
